// File: rtl/login_controller.sv
// Session front-end for the authenticator: card latch, decimal PIN assembly,
// retry limit with a per-account lock, entry timeout and session grant.
//
// state  | meaning
// IDLE   | waiting for card_in
// LOOKUP | one cycle, authenticator resolves acc_num
// ENTRY  | collecting keypad digits, timeout running
// CHECK  | one cycle, authenticator compares pin
// ACTIVE | authenticated session granted downstream
// EJECT  | one-cycle card return pulse
module login_controller #(
   parameter int MAX_ATTEMPTS   = 3,
   parameter int PIN_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        card_in,
   input  logic [3:0]  card_acc_num,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        clear,
   input  logic        cancel,
   input  logic        logout,
   input  logic        acc_found_stat,
   input  logic        acc_auth_stat,
   input  logic [3:0]  acc_index_in,
   output logic [3:0]  acc_num,
   output logic [15:0] pin,
   output logic        session_active,
   output logic [3:0]  session_acc_index,
   output logic [1:0]  attempts_left,
   output logic        eject,
   output logic [2:0]  err_code,
   output logic [2:0]  state
);

   localparam int CNT_W = $clog2(PIN_DIGITS + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      ENTRY  = 3'd2,
      CHECK  = 3'd3,
      ACTIVE = 3'd4,
      EJECT  = 3'd5
   } state_t;

   state_t             state_q, state_nxt;
   logic [3:0]         acc_q, acc_nxt;
   logic [15:0]        pin_q, pin_nxt;
   logic [3:0]         idx_q, idx_nxt;
   logic [1:0]         att_q, att_nxt;
   logic [2:0]         err_q, err_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic [TMR_W-1:0]   tmr_q, tmr_nxt;
   logic [15:0]        lock_q, lock_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         pin_q   <= '0;
         idx_q   <= '0;
         att_q   <= 2'(MAX_ATTEMPTS);
         err_q   <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_nxt;
         acc_q   <= acc_nxt;
         pin_q   <= pin_nxt;
         idx_q   <= idx_nxt;
         att_q   <= att_nxt;
         err_q   <= err_nxt;
         cnt_q   <= cnt_nxt;
         tmr_q   <= tmr_nxt;
         lock_q  <= lock_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      acc_nxt   = acc_q;
      pin_nxt   = pin_q;
      idx_nxt   = idx_q;
      att_nxt   = att_q;
      err_nxt   = err_q;
      cnt_nxt   = cnt_q;
      tmr_nxt   = tmr_q;
      lock_nxt  = lock_q;
      case (state_q)
         IDLE: begin
            if (card_in) begin
               acc_nxt = card_acc_num;
               err_nxt = 3'd0;
               if (lock_q[card_acc_num]) begin
                  state_nxt = EJECT;
                  err_nxt   = 3'd3;
               end else begin
                  state_nxt = LOOKUP;
               end
            end
         end
         LOOKUP: begin
            if (!acc_found_stat) begin
               state_nxt = EJECT;
               err_nxt   = 3'd1;
            end else begin
               state_nxt = ENTRY;
               pin_nxt   = '0;
               cnt_nxt   = '0;
               att_nxt   = 2'(MAX_ATTEMPTS);
               tmr_nxt   = '0;
            end
         end
         ENTRY: begin
            if (cancel) begin
               state_nxt = EJECT;
               err_nxt   = 3'd5;
            end else if (clear) begin
               pin_nxt = '0;
               cnt_nxt = '0;
               tmr_nxt = '0;
            end else if (digit_valid && digit <= 4'd9) begin
               pin_nxt = pin_q * 16'd10 + {12'd0, digit};
               cnt_nxt = cnt_q + 1'b1;
               tmr_nxt = '0;
               if (cnt_q == CNT_W'(PIN_DIGITS - 1))
                  state_nxt = CHECK;
            end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = EJECT;
               err_nxt   = 3'd4;
            end else begin
               tmr_nxt = tmr_q + 1'b1;
            end
         end
         CHECK: begin
            if (acc_auth_stat) begin
               state_nxt = ACTIVE;
               idx_nxt   = acc_index_in;
               err_nxt   = 3'd0;
            end else begin
               att_nxt = att_q - 1'b1;
               if (att_q == 2'd1) begin
                  lock_nxt[acc_q] = 1'b1;
                  state_nxt       = EJECT;
                  err_nxt         = 3'd3;
               end else begin
                  state_nxt = ENTRY;
                  err_nxt   = 3'd2;
                  pin_nxt   = '0;
                  cnt_nxt   = '0;
                  tmr_nxt   = '0;
               end
            end
         end
         ACTIVE: begin
            if (logout || cancel)
               state_nxt = EJECT;
         end
         EJECT: begin
            pin_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign acc_num           = acc_q;
   assign pin               = pin_q;
   assign session_active    = (state_q == ACTIVE);
   assign session_acc_index = idx_q;
   assign attempts_left     = att_q;
   assign eject             = (state_q == EJECT);
   assign err_code          = err_q;
   assign state             = state_q;

endmodule

// File: doc/login_controller.md
Name: login_controller

Overview:
- Session front-end that sits directly upstream of the authenticator.
- Accepts a card insertion (account number) and keypad digits, and assembles a decimal PIN value (e.g. keys 1,2,3,4 -> 1234).
- Drives acc_num/pin into the authenticator and samples its found/authenticated status.
- Enforces a retry limit with a per-account lock, plus an entry timeout.
- Grants an authenticated session to the downstream transaction stage.

Parameters:
MAX_ATTEMPTS, 3, wrong-PIN tries before the account is locked (1..3)
PIN_DIGITS, 4, digits per PIN entry
TIMEOUT_CYCLES, 1000, idle cycles allowed in ENTRY before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
card_in  in  1  one-cycle pulse, card inserted; card_acc_num valid same cycle
card_acc_num  in  4  account number on the card
digit_valid  in  1  keypad strobe, one cycle per key
digit  in  4  key value; 0..9 valid, 10..15 ignored
clear  in  1  discard partial PIN entry
cancel  in  1  abort session
logout  in  1  downstream stage ends authenticated session
acc_found_stat  in  1  from authenticator, 1 = account found
acc_auth_stat  in  1  from authenticator, 1 = PIN matches
acc_index_in  in  4  from authenticator, database index of account
acc_num  out  4  to authenticator, latched card account
pin  out  16  to authenticator, assembled PIN value
session_active  out  1  high while in ACTIVE
session_acc_index  out  4  index latched at successful auth
attempts_left  out  2  remaining tries
eject  out  1  one-cycle pulse, card returned
err_code  out  3  0 none, 1 not found, 2 wrong PIN, 3 locked, 4 timeout, 5 cancelled
state  out  3  current FSM state (debug)

Behaviour:
- Reset values (rst_n low at a clk edge): state IDLE; acc_num, pin, session_acc_index, err_code = 0; attempts_left = MAX_ATTEMPTS; session_active, eject = 0; digit count, timeout counter, and the 16-bit lock mask cleared.
- Reset mid-session returns to IDLE with no eject pulse.
- States: IDLE=0, LOOKUP=1, ENTRY=2, CHECK=3, ACTIVE=4, EJECT=5.
- IDLE:
  - On card_in: latch acc_num <= card_acc_num; err_code <= 0.
  - If lock_mask[card_acc_num] is set -> EJECT with err 3; else -> LOOKUP.
  - card_in is ignored in every other state.
- LOOKUP (exactly 1 cycle; the authenticator is combinational on acc_num):
  - acc_found_stat = 0 -> EJECT with err 1.
  - Otherwise -> ENTRY with pin = 0, digit count = 0, attempts_left = MAX_ATTEMPTS, timeout counter = 0.
- ENTRY, input priority per cycle is cancel > clear > digit:
  - cancel: -> EJECT with err 5.
  - clear: pin = 0 and count = 0; timeout counter restarts.
  - Accepted digit (digit_valid and digit <= 9): pin <= pin*10 + digit (16-bit, max 9999, no overflow); count++; timeout counter restarts.
  - Invalid digit: no state change and timeout counter does not restart.
  - When the PIN_DIGITS-th digit is accepted -> CHECK next cycle.
  - Timeout counter increments on every other cycle; reaching TIMEOUT_CYCLES -> EJECT with err 4.
- CHECK (exactly 1 cycle), pin held stable:
  - acc_auth_stat = 1 -> ACTIVE; session_acc_index <= acc_index_in; err_code <= 0.
  - Else attempts_left decrements.
    - If the result is 0 -> set lock_mask[acc_num], EJECT with err 3.
    - Otherwise err 2 and -> ENTRY with pin, count, and timeout cleared.
- ACTIVE:
  - session_active = 1; no timeout applies.
  - logout or cancel -> EJECT with err_code unchanged (0).
  - digit_valid and clear are ignored.
- EJECT: eject = 1 for this single cycle; pin cleared; -> IDLE.
- err_code holds until the next accepted card_in. attempts_left holds until the next LOOKUP.
- Lock mask persists across sessions and is cleared only by reset.
- pin output always reflects the internal PIN register.

Test Plan:
- Insert acc 1, keys 1,2,3,4, auth returns 1 -> pin=1234 in CHECK, ACTIVE with session_active=1, session_acc_index=0; logout -> eject pulse, IDLE, err 0.
- Acc 2, three entries of 1111 with auth=0 -> attempts_left 2,1, err 2 after each miss; third miss -> err 3, eject; re-insert acc 2 -> eject the cycle after card_in with err 3, LOOKUP not visited.
- Insert acc 12 with acc_found_stat=0 -> EJECT from LOOKUP, err 1, attempts_left unchanged.
- Acc 3, keys 3,4 then clear, then 3,4,5,6 -> pin=3456 at CHECK. A digit=11 strobe mid-entry -> pin and count unchanged.
- Acc 4, one digit, then TIMEOUT_CYCLES idle cycles (test with TIMEOUT_CYCLES=20) -> EJECT, err 4. Repeat with an invalid key at cycle 10 -> still times out at cycle 20.
- Acc 5, keys 5,6, rst_n low one cycle -> state IDLE, pin 0, no eject. Cancel and clear in the same ENTRY cycle -> EJECT with err 5.
